muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [CW-1:0]      cnt_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (b_i[cnt_i] ? {1'b0, a_i} : '0);
        // Dividend bits enter the remainder MSB first.
        shifted = {acc_i[2*WIDTH-1:WIDTH], a_i[TOP - cnt_i]};
        diff    = shifted - {1'b0, b_i};
        fits    = ~diff[WIDTH];
        acc_o   = '0;
        qbit_o  = 1'b0;
        if (div_i) begin
            acc_o  = {(fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                      acc_i[WIDTH-2:0], 1'b0};
            qbit_o = fits;
        end else begin
            acc_o  = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HiLo register.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic               HiLoEn,
    output logic [2*WIDTH-1:0] HiLoWrite,
    output logic               DivByZero
);

    localparam int CW = $clog2(WIDTH);

    state_e               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 sa_q;
    logic                 sb_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [5:0]           cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 en_q;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   hilo_q;

    logic [2*WIDTH-1:0]   step_acc;
    logic                 qbit;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 sgn_in;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .cnt_i  (cnt_q[CW-1:0]),
        .div_i  (op_is_div(op_q)),
        .acc_o  (step_acc),
        .qbit_o (qbit)
    );

    always_comb begin
        sgn_in = op_is_signed(Op);
        a_mag  = (sgn_in && A[WIDTH-1]) ? -A : A;
        b_mag  = (sgn_in && B[WIDTH-1]) ? -B : B;
        acc_d  = step_acc | {{(2*WIDTH-1){1'b0}}, qbit};
        // Sign flags are latched only for signed ops, so no op check here.
        quo    = (sa_q ^ sb_q) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        rem    = sa_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
        if (op_is_div(op_q)) begin
            result_d = {rem, quo};
        end else begin
            result_d = (sa_q ^ sb_q) ? -acc_d : acc_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            dbz_q   <= 1'b0;
            hilo_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        op_q   <= Op;
                        a_q    <= a_mag;
                        b_q    <= b_mag;
                        sa_q   <= sgn_in & A[WIDTH-1];
                        sb_q   <= sgn_in & B[WIDTH-1];
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (op_is_div(Op) && (B == '0)) begin
                            state_q <= FIX;
                            done_q  <= 1'b1;
                            en_q    <= 1'b1;
                            dbz_q   <= 1'b1;
                            hilo_q  <= {A, {WIDTH{1'b1}}};
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) begin
                        state_q <= FIX;
                        done_q  <= 1'b1;
                        en_q    <= 1'b1;
                        hilo_q  <= result_d;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    en_q    <= 1'b0;
                    dbz_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign HiLoEn    = en_q;
    assign DivByZero = dbz_q;
    assign HiLoWrite = hilo_q;

endmodule
